// File: rtl/fc_fetch_unit.sv
// ---------------------------------------------------------------------------
// fc_fetch_unit
//   Instruction fetch stage for the FlexiCore datapath. It holds the PC and
//   issues one ROM read at a time. It registers the returned instruction and
//   presents it to decode over a valid/ready handshake. A branch redirect from
//   execute is taken only in the handshake cycle.
//
//   Ports
//     i_clk        clock, all state updates on posedge
//     i_rst        synchronous, active-high reset
//     i_en         run enable; fetch starts/continues only when 1
//     o_rom_req    ROM read request (registered)
//     o_rom_addr   ROM read address (registered, equals PC)
//     i_rom_vld    ROM data valid; completes the outstanding request
//     i_rom_data   ROM read data, sampled on o_rom_req & i_rom_vld
//     o_instr_vld  o_instr / o_instr_pc valid to decode (registered)
//     i_instr_rdy  decode accepts; handshake = o_instr_vld & i_instr_rdy
//     o_instr      fetched instruction (registered)
//     o_instr_pc   address o_instr was fetched from (registered)
//     i_br_taken   redirect, sampled only in the handshake cycle
//     i_br_tgt     redirect target, sampled with i_br_taken
// ---------------------------------------------------------------------------
module fc_fetch_unit #(
    parameter int unsigned     PC_W     = 7,
    parameter int unsigned     INSTR_W  = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    output logic               o_rom_req,
    output logic [PC_W-1:0]    o_rom_addr,
    input  logic               i_rom_vld,
    input  logic [INSTR_W-1:0] i_rom_data,
    output logic               o_instr_vld,
    input  logic               i_instr_rdy,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_instr_pc,
    input  logic               i_br_taken,
    input  logic [PC_W-1:0]    i_br_tgt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,  // stopped, no request
        S_WAIT = 2'd1,  // request outstanding at r_pc
        S_HOLD = 2'd2   // instruction presented, waiting for decode
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_rom_req;
    logic                 r_instr_vld;
    logic [PC_W-1:0]      r_pc;
    logic [INSTR_W-1:0]   r_instr;
    logic [PC_W-1:0]      r_instr_pc;

    logic                 w_handshake;
    logic                 w_rom_done;
    logic [PC_W-1:0]      w_pc_inc;

    assign w_handshake = r_instr_vld & i_instr_rdy;
    // ROM_VLD outside WAIT (e.g. a late response after reset) is ignored.
    assign w_rom_done  = (r_state == S_WAIT) & i_rom_vld;
    // PC_W-bit incrementer; the carry is dropped so the PC wraps to 0.
    assign w_pc_inc    = r_pc + PC_W'(1);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: default assigned first so every path drives w_next_state and
        // no latch is inferred.
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: if (i_en)       w_next_state = S_WAIT;
            // Dropping i_en while waiting does not abort the request.
            S_WAIT: if (i_rom_vld)  w_next_state = S_HOLD;
            S_HOLD: if (w_handshake) w_next_state = i_en ? S_WAIT : S_IDLE;
            default:                w_next_state = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State and handshake flags. These are decoded from the next state so that
    // o_rom_req / o_instr_vld come straight from flops.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        // NOTE: reset is synchronous, so it is an ordinary highest-priority
        // branch inside the clocked block and is not in the sensitivity list.
        if (i_rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            r_state     <= S_IDLE;
            r_rom_req   <= 1'b0;
            r_instr_vld <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_rom_req   <= (w_next_state == S_WAIT);
            r_instr_vld <= (w_next_state == S_HOLD);
        end
    end

    // -----------------------------------------------------------------------
    // PC and instruction registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else if (w_rom_done) begin
            r_instr    <= i_rom_data;
            r_instr_pc <= r_pc;
            r_pc       <= w_pc_inc;
        end else if (w_handshake && i_br_taken) begin
            // A handshake only happens in HOLD, so it never coincides with
            // w_rom_done. Without a branch the PC already points past the
            // presented instruction.
            r_pc       <= i_br_tgt;
        end
    end

    assign o_rom_req   = r_rom_req;
    assign o_rom_addr  = r_pc;
    assign o_instr_vld = r_instr_vld;
    assign o_instr     = r_instr;
    assign o_instr_pc  = r_instr_pc;

endmodule

// File: tb/tb_fc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fc_fetch_unit
//   Directed bench for fc_fetch_unit. A ROM responder answers requests with
//   data = addr ^ 0xA5 after a programmable number of wait cycles. Expected
//   instructions are queued as the stimulus issues them. A monitor pops the
//   queue on every decode handshake. Cycle-level checks cover reset, wait
//   states, backpressure, branch/wrap and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_fc_fetch_unit;

    localparam int PC_W    = 7;
    localparam int INSTR_W = 8;

    logic               clk;
    logic               rst;
    logic               en;
    logic               rom_req;
    logic [PC_W-1:0]    rom_addr;
    logic               rom_vld;
    logic [INSTR_W-1:0] rom_data;
    logic               instr_vld;
    logic               instr_rdy;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic               br_taken;
    logic [PC_W-1:0]    br_tgt;

    fc_fetch_unit #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (7'h00)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .o_rom_req   (rom_req),
        .o_rom_addr  (rom_addr),
        .i_rom_vld   (rom_vld),
        .i_rom_data  (rom_data),
        .o_instr_vld (instr_vld),
        .i_instr_rdy (instr_rdy),
        .o_instr     (instr),
        .o_instr_pc  (instr_pc),
        .i_br_taken  (br_taken),
        .i_br_tgt    (br_tgt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;

    // ROM behaviour: 0 silent, 1 auto-respond, 2 random junk, 3 forced valid.
    int   rom_mode;
    int   rom_wait;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [INSTR_W-1:0] i, input logic [PC_W-1:0] p);
        exp_t e;
        e.instr = i;
        e.pc    = p;
        sb.push_back(e);
    endtask

    // Inputs change 1 time unit after the rising edge; checks run on the
    // falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ROM responder: sole driver of rom_vld / rom_data. It runs after the
    // stimulus in each cycle so it sees the mode chosen for that cycle.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        rom_vld  = 1'b0;
        rom_data = '0;
        forever begin
            @(posedge clk);
            #2;
            case (rom_mode)
                1: begin
                    if (rom_req) begin
                        if (wait_cnt == rom_wait) begin
                            rom_vld  = 1'b1;
                            rom_data = {1'b0, rom_addr} ^ 8'hA5;
                            wait_cnt = 0;
                        end else begin
                            rom_vld  = 1'b0;
                            rom_data = 8'($urandom_range(0, 255));
                            wait_cnt++;
                        end
                    end else begin
                        rom_vld  = 1'b0;
                        wait_cnt = 0;
                    end
                end
                2: begin
                    rom_vld  = 1'($urandom_range(0, 1));
                    rom_data = 8'($urandom_range(0, 255));
                end
                3: begin
                    rom_vld  = 1'b1;
                    rom_data = 8'hEE;
                end
                default: begin
                    rom_vld  = 1'b0;
                    wait_cnt = 0;
                end
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic pat[7];
        n_cmp     = 0;
        n_err     = 0;
        rom_mode  = 2;
        rom_wait  = 0;
        rst       = 1'b1;
        en        = 1'($urandom_range(0, 1));
        instr_rdy = 1'($urandom_range(0, 1));
        br_taken  = 1'($urandom_range(0, 1));
        br_tgt    = 7'($urandom_range(0, 127));

        // Scoreboard monitor: pops one expectation per decode handshake.
        fork
            forever begin
                @(negedge clk);
                if (!rst && instr_vld === 1'b1 && instr_rdy === 1'b1) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL sb_unexpected: got instr 0x%0h pc 0x%0h, expected no handshake at %0t",
                                 instr, instr_pc, $time);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("sb_instr", 32'(instr), 32'(e.instr));
                        check("sb_pc", 32'(instr_pc), 32'(e.pc));
                    end
                end
            end
        join_none

        // ---- T1: reset with random inputs ----
        repeat (2) begin
            next_cycle();
            en        = 1'($urandom_range(0, 1));
            instr_rdy = 1'($urandom_range(0, 1));
            br_taken  = 1'($urandom_range(0, 1));
            br_tgt    = 7'($urandom_range(0, 127));
        end
        @(negedge clk);
        check("t1_rom_req", 32'(rom_req), 0);
        check("t1_instr_vld", 32'(instr_vld), 0);
        check("t1_instr", 32'(instr), 0);
        check("t1_instr_pc", 32'(instr_pc), 0);
        check("t1_rom_addr", 32'(rom_addr), 0);

        next_cycle();
        rst       = 1'b0;
        en        = 1'b0;
        instr_rdy = 1'b0;
        br_taken  = 1'b0;
        br_tgt    = '0;
        rom_mode  = 1;
        rom_wait  = 0;

        // ---- T2: zero-wait stream, one instruction per 2 cycles ----
        next_cycle();
        push_exp(8'hA5, 7'd0);
        push_exp(8'hA4, 7'd1);
        push_exp(8'hA7, 7'd2);
        en        = 1'b1;
        instr_rdy = 1'b1;
        pat       = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            if (i == 6) en = 1'b0;
            @(negedge clk);
            check($sformatf("t2_vld_c%0d", i), 32'(instr_vld), 32'(pat[i]));
            next_cycle();
        end

        // ---- T3: 3 wait states at PC=3 ----
        rom_wait = 3;
        en       = 1'b1;
        push_exp(8'hA6, 7'd3);
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            @(negedge clk);
            check($sformatf("t3_req_d%0d", i), 32'(rom_req), 1);
            check($sformatf("t3_addr_d%0d", i), 32'(rom_addr), 3);
            check($sformatf("t3_vld_d%0d", i), 32'(instr_vld), 0);
        end
        next_cycle();
        en = 1'b0;
        @(negedge clk);
        check("t3_vld_rise", 32'(instr_vld), 1);
        check("t3_req_drop", 32'(rom_req), 0);
        next_cycle();

        // ---- T4: backpressure at PC=4, stray branch pulses ----
        rom_wait  = 0;
        instr_rdy = 1'b0;
        en        = 1'b1;
        push_exp(8'hA1, 7'd4);
        push_exp(8'hA0, 7'd5);
        next_cycle();
        @(negedge clk);
        check("t4_req_e1", 32'(rom_req), 1);
        check("t4_addr_e1", 32'(rom_addr), 4);
        for (int i = 2; i <= 5; i++) begin
            next_cycle();
            if (i == 3) begin
                br_taken = 1'b1;
                br_tgt   = 7'h22;
            end else begin
                br_taken = 1'b0;
            end
            @(negedge clk);
            check($sformatf("t4_vld_e%0d", i), 32'(instr_vld), 1);
            check($sformatf("t4_instr_e%0d", i), 32'(instr), 32'h A1);
            check($sformatf("t4_pc_e%0d", i), 32'(instr_pc), 4);
            check($sformatf("t4_req_e%0d", i), 32'(rom_req), 0);
        end
        next_cycle();
        br_taken  = 1'b0;
        instr_rdy = 1'b1;
        @(negedge clk);
        check("t4_vld_e6", 32'(instr_vld), 1);
        next_cycle();
        br_taken = 1'b1;
        br_tgt   = 7'h33;
        @(negedge clk);
        check("t4_req_after_rdy", 32'(rom_req), 1);
        check("t4_addr_after_rdy", 32'(rom_addr), 5);

        // ---- T5: branch to 0x7F on handshake of PC=5, then wrap ----
        next_cycle();
        br_taken = 1'b1;
        br_tgt   = 7'h7F;
        push_exp(8'hDA, 7'h7F);
        push_exp(8'hA5, 7'h00);
        @(negedge clk);
        check("t5_vld_pc5", 32'(instr_vld), 1);
        check("t5_pc5", 32'(instr_pc), 5);
        next_cycle();
        br_taken = 1'b0;
        @(negedge clk);
        check("t5_req_tgt", 32'(rom_req), 1);
        check("t5_addr_tgt", 32'(rom_addr), 32'h7F);
        next_cycle();
        @(negedge clk);
        check("t5_pc_7f", 32'(instr_pc), 32'h7F);
        next_cycle();
        @(negedge clk);
        check("t5_req_wrap", 32'(rom_req), 1);
        check("t5_addr_wrap", 32'(rom_addr), 0);
        next_cycle();
        en = 1'b0;
        @(negedge clk);
        check("t5_pc_wrap", 32'(instr_pc), 0);
        next_cycle();

        // ---- T6: reset while waiting at 0x10, late ROM_VLD ----
        en = 1'b1;
        push_exp(8'hA4, 7'd1);
        push_exp(8'hA5, 7'd0);
        next_cycle();
        @(negedge clk);
        check("t6_addr_1", 32'(rom_addr), 1);
        next_cycle();
        br_taken = 1'b1;
        br_tgt   = 7'h10;
        next_cycle();
        br_taken = 1'b0;
        rom_mode = 0;
        rst      = 1'b1;
        @(negedge clk);
        check("t6_req_10", 32'(rom_req), 1);
        check("t6_addr_10", 32'(rom_addr), 32'h10);
        next_cycle();
        rst      = 1'b0;
        rom_mode = 3;
        @(negedge clk);
        check("t6_req_after_rst", 32'(rom_req), 0);
        check("t6_vld_after_rst", 32'(instr_vld), 0);
        check("t6_addr_after_rst", 32'(rom_addr), 0);
        check("t6_instr_after_rst", 32'(instr), 0);
        check("t6_pc_after_rst", 32'(instr_pc), 0);
        next_cycle();
        rom_mode = 1;
        @(negedge clk);
        check("t6_req_restart", 32'(rom_req), 1);
        check("t6_addr_restart", 32'(rom_addr), 0);
        next_cycle();
        en = 1'b0;
        next_cycle();
        repeat (3) next_cycle();
        @(negedge clk);
        check("end_vld_idle", 32'(instr_vld), 0);
        check("end_req_idle", 32'(rom_req), 0);
        check("sb_empty", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
